vec3_fxp_xdot_unit: RTL and testbench

// - Sequential 3-vector product engine. Next generation of the cross-product stage in the 3D pipeline.
// - Signed fixed-point, parametrised width and fraction. Two modes: cross product and dot product.
// - One time-multiplexed multiplier; valid/ready handshakes on input and output; optional saturation.
// - Sits between the vertex/normal source and the lighting stage.

---
 rtl/vec3_pkg.sv | 30 +++
 rtl/fxp_norm_sat.sv | 32 +++
 rtl/vec3_fxp_xdot_unit.sv | 160 ++++++++++++++++
 tb/tb_vec3_fxp_xdot_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec3_pkg.sv
// Shared types, product counts and operand-select schedules for the vec3 product engine.
package vec3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        OUT  = 2'd3
    } vec3_state_t;

    typedef enum logic {
        MODE_CROSS = 1'b0,
        MODE_DOT   = 1'b1
    } vec3_mode_t;

    localparam logic [2:0] CROSS_N_PROD = 3'd6;
    localparam logic [2:0] DOT_N_PROD   = 3'd3;

    // 2-bit component index per product step (0=x, 1=y, 2=z), step 0 in the LSBs.
    // Cross: p0=ay*bz p1=az*by p2=az*bx p3=ax*bz p4=ax*by p5=ay*bx
    localparam logic [11:0] CROSS_A_SEL = {2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
    localparam logic [11:0] CROSS_B_SEL = {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    localparam logic [11:0] DOT_A_SEL   = {6'd0, 2'd2, 2'd1, 2'd0};
    localparam logic [11:0] DOT_B_SEL   = {6'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] sel_entry(input logic [11:0] tbl, input logic [2:0] idx);
        sel_entry = tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/fxp_norm_sat.sv
// Rescales a full-precision sum by FRAC (floor) and either clamps or wraps it to WIDTH bits.
module fxp_norm_sat #(
    parameter int IN_W     = 66,
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [IN_W-1:0]  value_i,
    output logic signed [WIDTH-1:0] value_o,
    output logic                    sat_o
);

    logic signed [IN_W-1:0]  shifted;
    logic [IN_W-WIDTH:0]     top_bits;
    logic                    overflow;

    assign shifted  = value_i >>> FRAC;
    // The value fits in WIDTH bits only when everything from bit WIDTH-1 up is a sign copy.
    assign top_bits = shifted[IN_W-1:WIDTH-1];
    assign overflow = !((&top_bits) || !(|top_bits));

    always_comb begin
        value_o = shifted[WIDTH-1:0];
        sat_o   = 1'b0;
        if (SATURATE && overflow) begin
            sat_o   = 1'b1;
            value_o = shifted[IN_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vec3_fxp_xdot_unit.sv
// Sequential fixed-point cross/dot product engine built around one shared multiplier.
module vec3_fxp_xdot_unit
    import vec3_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] vec_ax,
    input  logic [WIDTH-1:0] vec_ay,
    input  logic [WIDTH-1:0] vec_az,
    input  logic [WIDTH-1:0] vec_bx,
    input  logic [WIDTH-1:0] vec_by,
    input  logic [WIDTH-1:0] vec_bz,
    output logic             vec_ready,
    output logic [WIDTH-1:0] value_out_x,
    output logic [WIDTH-1:0] value_out_y,
    output logic [WIDTH-1:0] value_out_z,
    output logic             sat_out,
    output logic             valid_out,
    input  logic             result_ready_in
);

    localparam int SUM_W = 2*WIDTH + 2;

    vec3_state_t              state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    vec3_mode_t               mode_q;
    logic signed [WIDTH-1:0]  a_q [3];
    logic signed [WIDTH-1:0]  b_q [3];
    logic signed [2*WIDTH-1:0] p_q [6];
    logic signed [WIDTH-1:0]  val_q [3];
    logic                     sat_q;

    logic                     accept;
    logic [2:0]               last_idx;
    logic [1:0]               a_sel, b_sel;
    logic signed [WIDTH-1:0]  a_op, b_op;
    logic signed [2*WIDTH-1:0] product;
    logic signed [SUM_W-1:0]  sum [3];
    logic signed [WIDTH-1:0]  norm_val [3];
    logic [2:0]               norm_sat;

    assign accept   = valid_in && (state_q == IDLE);
    assign last_idx = (mode_q == MODE_DOT) ? (DOT_N_PROD - 3'd1) : (CROSS_N_PROD - 3'd1);
    assign a_sel    = (mode_q == MODE_DOT) ? sel_entry(DOT_A_SEL, idx_q) : sel_entry(CROSS_A_SEL, idx_q);
    assign b_sel    = (mode_q == MODE_DOT) ? sel_entry(DOT_B_SEL, idx_q) : sel_entry(CROSS_B_SEL, idx_q);

    always_comb begin
        a_op = a_q[2];
        b_op = b_q[2];
        case (a_sel)
            2'd0:    a_op = a_q[0];
            2'd1:    a_op = a_q[1];
            default: a_op = a_q[2];
        endcase
        case (b_sel)
            2'd0:    b_op = b_q[0];
            2'd1:    b_op = b_q[1];
            default: b_op = b_q[2];
        endcase
    end

    assign product = a_op * b_op;

    // Combine products at full precision so the subtraction/addition can never overflow.
    always_comb begin
        sum[0] = '0;
        sum[1] = '0;
        sum[2] = '0;
        if (mode_q == MODE_DOT) begin
            sum[0] = SUM_W'(p_q[0]) + SUM_W'(p_q[1]) + SUM_W'(p_q[2]);
        end else begin
            sum[0] = SUM_W'(p_q[0]) - SUM_W'(p_q[1]);
            sum[1] = SUM_W'(p_q[2]) - SUM_W'(p_q[3]);
            sum[2] = SUM_W'(p_q[4]) - SUM_W'(p_q[5]);
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_norm
        fxp_norm_sat #(
            .IN_W     (SUM_W),
            .WIDTH    (WIDTH),
            .FRAC     (FRAC),
            .SATURATE (SATURATE)
        ) u_norm (
            .value_i (sum[gi]),
            .value_o (norm_val[gi]),
            .sat_o   (norm_sat[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MUL;
                    idx_d   = 3'd0;
                end
            end
            MUL: begin
                if (idx_q == last_idx) begin
                    state_d = NORM;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            NORM:    state_d = OUT;
            default: begin
                if (result_ready_in) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            mode_q  <= MODE_CROSS;
            sat_q   <= 1'b0;
            for (int i = 0; i < 3; i++) val_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) mode_q <= vec3_mode_t'(mode_in);
            if (state_q == NORM) begin
                for (int i = 0; i < 3; i++) val_q[i] <= norm_val[i];
                sat_q <= |norm_sat;
            end
        end
    end

    // Operand and product registers are pure datapath; the FSM decides when they matter.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            a_q[0] <= vec_ax;
            a_q[1] <= vec_ay;
            a_q[2] <= vec_az;
            b_q[0] <= vec_bx;
            b_q[1] <= vec_by;
            b_q[2] <= vec_bz;
        end
        if (state_q == MUL) p_q[idx_q] <= product;
    end

    assign vec_ready   = (state_q == IDLE);
    assign valid_out   = (state_q == OUT);
    assign value_out_x = val_q[0];
    assign value_out_y = val_q[1];
    assign value_out_z = val_q[2];
    assign sat_out     = sat_q;

endmodule

// File: tb/tb_vec3_fxp_xdot_unit.sv
// Directed table-driven bench for vec3_fxp_xdot_unit, with a saturating and a wrapping instance.
module tb_vec3_fxp_xdot_unit;

    logic        clk_in = 1'b0;
    logic        rst_in, valid_in, mode_in, result_ready_in;
    logic [31:0] vec_ax, vec_ay, vec_az, vec_bx, vec_by, vec_bz;
    logic        vec_ready, sat_out, valid_out;
    logic [31:0] value_out_x, value_out_y, value_out_z;
    logic        w_ready, w_sat, w_valid;
    logic [31:0] w_x, w_y, w_z;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    vec3_fxp_xdot_unit #(.WIDTH(32), .FRAC(16), .SATURATE(1'b1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .mode_in(mode_in),
        .vec_ax(vec_ax), .vec_ay(vec_ay), .vec_az(vec_az),
        .vec_bx(vec_bx), .vec_by(vec_by), .vec_bz(vec_bz),
        .vec_ready(vec_ready), .value_out_x(value_out_x), .value_out_y(value_out_y),
        .value_out_z(value_out_z), .sat_out(sat_out), .valid_out(valid_out),
        .result_ready_in(result_ready_in)
    );

    vec3_fxp_xdot_unit #(.WIDTH(32), .FRAC(16), .SATURATE(1'b0)) u_wrap (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .mode_in(mode_in),
        .vec_ax(vec_ax), .vec_ay(vec_ay), .vec_az(vec_az),
        .vec_bx(vec_bx), .vec_by(vec_by), .vec_bz(vec_bz),
        .vec_ready(w_ready), .value_out_x(w_x), .value_out_y(w_y),
        .value_out_z(w_z), .sat_out(w_sat), .valid_out(w_valid),
        .result_ready_in(result_ready_in)
    );

    typedef struct {
        logic        mode;
        logic [31:0] ax, ay, az, bx, by, bz;
        logic [31:0] ex, ey, ez;
        logic        es;
        logic [31:0] wx, wy, wz;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input logic m,
                                input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] az,
                                input logic [31:0] bx, input logic [31:0] by, input logic [31:0] bz,
                                input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                                input logic es,
                                input logic [31:0] wx, input logic [31:0] wy, input logic [31:0] wz);
        vec_t v;
        v.mode = m;
        v.ax = ax; v.ay = ay; v.az = az;
        v.bx = bx; v.by = by; v.bz = bz;
        v.ex = ex; v.ey = ey; v.ez = ez; v.es = es;
        v.wx = wx; v.wy = wy; v.wz = wz;
        v.lat = m ? 4 : 7;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input vec_t v);
        mode_in = v.mode;
        vec_ax = v.ax; vec_ay = v.ay; vec_az = v.az;
        vec_bx = v.bx; vec_by = v.by; vec_bz = v.bz;
    endtask

    // Waits (bounded) for valid_out after an accept edge and returns cycles elapsed.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (cnt < 20) begin
            tick();
            cnt++;
            if (valid_out) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        check({tag, " ready_before"}, 32'(vec_ready), 32'd1);
        drive(v);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(cnt);
        check({tag, " latency"}, 32'(cnt), 32'(v.lat));
        check({tag, " x"}, value_out_x, v.ex);
        check({tag, " y"}, value_out_y, v.ey);
        check({tag, " z"}, value_out_z, v.ez);
        check({tag, " sat"}, 32'(sat_out), 32'(v.es));
        check({tag, " wrap_valid"}, 32'(w_valid), 32'd1);
        check({tag, " wrap_x"}, w_x, v.wx);
        check({tag, " wrap_y"}, w_y, v.wy);
        check({tag, " wrap_z"}, w_z, v.wz);
        check({tag, " wrap_sat"}, 32'(w_sat), 32'd0);
        check({tag, " busy"}, 32'(vec_ready), 32'd0);
        result_ready_in = 1'b1;
        tick();
        result_ready_in = 1'b0;
        check({tag, " valid_drop"}, 32'(valid_out), 32'd0);
        check({tag, " ready_after"}, 32'(vec_ready), 32'd1);
        $display("vector %s: x=%h y=%h z=%h sat=%0d latency=%0d", tag,
                 v.ex, v.ey, v.ez, v.es, cnt);
    endtask

    initial begin
        int cnt;
        int seen;
        vec_t junk;

        //            mode  ax            ay            az            bx            by            bz
        //                  ex            ey            ez            es    wx            wy            wz
        tbl[0] = mk(1'b0, 32'h0004_0000, 32'h0009_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'hFFF7_0000, 1'b0, 32'h0, 32'h0, 32'hFFF7_0000);
        tbl[1] = mk(1'b1, 32'h0004_0000, 32'h0009_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0,
                    32'h0004_0000, 32'h0, 32'h0, 1'b0, 32'h0004_0000, 32'h0, 32'h0);
        tbl[2] = mk(1'b0, 32'h7FFF_0000, 32'h0, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0,
                    32'h0, 32'h0, 32'h7FFF_FFFF, 1'b1, 32'h0, 32'h0, 32'h0001_0000);
        tbl[3] = mk(1'b0, 32'h0, 32'h0000_8000, 32'h0, 32'h0, 32'h0, 32'hFFFF_8000,
                    32'hFFFF_C000, 32'h0, 32'h0, 1'b0, 32'hFFFF_C000, 32'h0, 32'h0);
        tbl[4] = mk(1'b0, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        tbl[5] = mk(1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                    32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
                    32'hFFFD_0000, 32'h0006_0000, 32'hFFFD_0000, 1'b0,
                    32'hFFFD_0000, 32'h0006_0000, 32'hFFFD_0000);
        tbl[6] = mk(1'b1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                    32'h0004_0000, 32'hFFFB_0000, 32'h0006_0000,
                    32'h000C_0000, 32'h0, 32'h0, 1'b0, 32'h000C_0000, 32'h0, 32'h0);
        tbl[7] = mk(1'b1, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0,
                    32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 32'h0002_0000, 32'h0, 32'h0);
        tbl[8] = mk(1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0,
                    32'h0, 32'h0, 32'h8000_0000, 1'b1, 32'h0, 32'h0, 32'h8000_0000);

        rst_in = 1'b1; valid_in = 1'b0; result_ready_in = 1'b0;
        junk = tbl[0];
        drive(junk);
        repeat (3) tick();
        rst_in = 1'b0;
        check("reset ready", 32'(vec_ready), 32'd1);
        check("reset valid", 32'(valid_out), 32'd0);
        check("reset x", value_out_x, 32'h0);
        check("reset y", value_out_y, 32'h0);
        check("reset z", value_out_z, 32'h0);
        check("reset sat", 32'(sat_out), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Backpressure: hold off the output, poke valid_in while busy and at the handshake.
        drive(tbl[0]);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(cnt);
        check("bp latency", 32'(cnt), 32'd7);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                drive(tbl[7]);
                valid_in = 1'b1;
            end
            tick();
            valid_in = 1'b0;
            check($sformatf("bp valid c%0d", k), 32'(valid_out), 32'd1);
            check($sformatf("bp z c%0d", k), value_out_z, 32'hFFF7_0000);
            check($sformatf("bp ready c%0d", k), 32'(vec_ready), 32'd0);
        end
        check("bp x", value_out_x, 32'h0);
        check("bp sat", 32'(sat_out), 32'd0);
        drive(tbl[5]);
        result_ready_in = 1'b1;
        valid_in = 1'b1;
        tick();
        result_ready_in = 1'b0;
        valid_in = 1'b0;
        check("bp valid_drop", 32'(valid_out), 32'd0);
        check("bp ready_after", 32'(vec_ready), 32'd1);
        tick();
        check("bp no_accept_in_out", 32'(vec_ready), 32'd1);
        $display("backpressure: 5 stall cycles, z=%h held", value_out_z);

        // Reset three cycles after accept: operation is dropped entirely.
        drive(tbl[5]);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("midrst ready", 32'(vec_ready), 32'd1);
        check("midrst valid", 32'(valid_out), 32'd0);
        check("midrst z", value_out_z, 32'h0);
        check("midrst sat", 32'(sat_out), 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid_out) seen++;
        end
        check("midrst no_pulse", 32'(seen), 32'd0);
        $display("mid-op reset: outputs cleared, no valid pulse");
        run_vec(tbl[5], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
